// File: rtl/multiplier_pkg.sv
// Shared core constants for the multi-cycle MUL unit: FSM state encoding
// (also referenced by the ALU decode logic when stalling on MUL) and a
// helper that sizes the step counter.
package multiplier_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN,
        S_DONE = ST_DONE
    } mul_state_t;

    // Counter width able to hold 0..n (the step counter ends one past N-1).
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/multiplier_adder.sv
// Single N-bit ripple adder shared across all shift-and-add steps.
// Produces the N-bit sum and the carry out; gating by the multiplier
// bit is done by the caller.
module multiplier_adder #(
    parameter int N = 8
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    output logic [N-1:0] o_sum,
    output logic         o_carry
);

    logic [N:0] w_full;

    assign w_full  = {1'b0, i_a} + {1'b0, i_b};
    assign o_sum   = w_full[N-1:0];
    assign o_carry = w_full[N];

endmodule

// File: rtl/multiplier.sv
// Sequential shift-and-add unsigned multiplier. One adder is reused over
// N RUN cycles to build a 2N-bit product; start/ready/done handshake lets
// the issuing logic stall on it.
module multiplier
    import multiplier_pkg::*;
#(
    parameter int N = 8
) (
    input  logic           i_clock,
    input  logic           i_reset,
    input  logic           i_start,
    input  logic [N-1:0]   i_multiplicand,
    input  logic [N-1:0]   i_multiplier,
    output logic           o_ready,
    output logic           o_done,
    output logic [2*N-1:0] o_product
);

    localparam int            CW   = cnt_width(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    mul_state_t    r_state;
    mul_state_t    w_state_next;
    logic [N-1:0]  r_mcand;
    logic [N-1:0]  r_acc_hi;
    logic [N-1:0]  r_acc_lo;
    logic [CW-1:0] r_count;

    logic          w_accept;
    logic          w_ready;
    logic          w_done;
    logic [N-1:0]  w_sum;
    logic          w_carry;
    logic          w_add;
    logic [N-1:0]  w_hi_in;
    logic          w_c_in;

    multiplier_adder #(
        .N(N)
    ) u_adder (
        .i_a     (r_acc_hi),
        .i_b     (r_mcand),
        .o_sum   (w_sum),
        .o_carry (w_carry)
    );

    // Add the multiplicand only when the current multiplier bit is set;
    // otherwise pass the upper half through with no carry.
    assign w_add   = r_acc_lo[0];
    assign w_hi_in = w_add ? w_sum : r_acc_hi;
    assign w_c_in  = w_add & w_carry;

    // State register.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and handshake decode; ready/done depend on state only.
    always_comb begin
        w_state_next = r_state;
        w_ready      = 1'b0;
        w_done       = 1'b0;
        w_accept     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_ready = 1'b1;
                if (i_start) begin
                    w_accept     = 1'b1;
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (r_count == LAST) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_done       = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Datapath: load operands on accept, then one add/shift step per RUN
    // cycle. The adder carry becomes the new top bit of the upper half.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_mcand  <= '0;
            r_acc_hi <= '0;
            r_acc_lo <= '0;
            r_count  <= '0;
        end else if (w_accept) begin
            r_mcand  <= i_multiplicand;
            r_acc_hi <= '0;
            r_acc_lo <= i_multiplier;
            r_count  <= '0;
        end else if (r_state == S_RUN) begin
            {r_acc_hi, r_acc_lo} <= {w_c_in, w_hi_in, r_acc_lo[N-1:1]};
            r_count              <= r_count + CW'(1);
        end
    end

    assign o_ready   = w_ready;
    assign o_done    = w_done;
    assign o_product = {r_acc_hi, r_acc_lo};

endmodule

// File: tb/tb_multiplier.sv
// Scoreboard bench for the shift-and-add multiplier: stimulus pushes the
// hand-computed product on every accept, a monitor pops and compares on
// every o_done pulse.
module tb_multiplier;

    localparam int N = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic           ready;
    logic           done;
    logic [2*N-1:0] prod;

    always #5 clk = ~clk;

    multiplier #(
        .N(N)
    ) dut (
        .i_clock        (clk),
        .i_reset        (rst),
        .i_start        (start),
        .i_multiplicand (a),
        .i_multiplier   (b),
        .o_ready        (ready),
        .o_done         (done),
        .o_product      (prod)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [2*N-1:0] exp_q[$];
    int s_tests = 0;
    int s_fail = 0;
    int done_cnt = 0;
    int last_done_cyc = 0;

    // Monitor: every done pulse consumes one expected product.
    always @(negedge clk) begin
        if (!rst && done) begin
            done_cnt      <= done_cnt + 1;
            last_done_cyc <= cyc;
            s_tests       <= s_tests + 1;
            if (exp_q.size() == 0) begin
                s_fail <= s_fail + 1;
                $display("FAIL unexpected_done product=%0d required=none", prod);
            end else begin
                if (prod !== exp_q[0]) begin
                    s_fail <= s_fail + 1;
                    $display("FAIL product got=%0d required=%0d", prod, exp_q[0]);
                end
                void'(exp_q.pop_front());
            end
        end
    end

    int m_tests = 0;
    int m_fail = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int req);
        m_tests++;
        if (act !== req) begin
            m_fail++;
            $display("FAIL %s got=%0d required=%0d", nm, act, req);
        end
    endtask

    task automatic wait_done(output int dc);
        int  prev;
        bit  got;
        prev = done_cnt;
        got  = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            tick();
            if (done_cnt != prev) got = 1'b1;
        end
        chk("done_seen", int'(got), 1);
        dc = last_done_cyc;
    endtask

    task automatic op(input logic [N-1:0] ai, input logic [N-1:0] bi,
                      input logic [2*N-1:0] pe);
        int acc;
        int dc;
        for (int i = 0; i < 30 && !ready; i++) tick();
        start = 1'b1;
        a     = ai;
        b     = bi;
        tick();
        acc   = cyc;
        start = 1'b0;
        exp_q.push_back(pe);
        a     = ~ai;
        b     = ~bi;
        wait_done(dc);
        chk("latency", dc - acc, N);
        chk("ready_after_done", int'(ready), 1);
        chk("done_one_cycle", int'(done), 0);
    endtask

    int acc1;
    int acc2;
    int d1;
    int d2;
    int dcnt0;

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        tick();
        tick();
        chk("reset_ready", int'(ready), 1);
        chk("reset_done", int'(done), 0);
        chk("reset_product", int'(prod), 0);
        rst = 1'b0;
        tick();

        op(8'd13, 8'd11, 16'd143);
        op(8'd255, 8'd255, 16'd65025);

        op(8'd0, 8'd200, 16'd0);
        op(8'd200, 8'd0, 16'd0);
        op(8'd1, 8'd1, 16'd1);
        tick();
        tick();
        tick();
        chk("product_hold", int'(prod), 1);

        // Requests during RUN and DONE are ignored.
        start = 1'b1;
        a     = 8'd7;
        b     = 8'd9;
        tick();
        acc1  = cyc;
        start = 1'b0;
        exp_q.push_back(16'd63);
        tick();
        tick();
        chk("ready_in_run", int'(ready), 0);
        a     = 8'd3;
        b     = 8'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("ready_in_run2", int'(ready), 0);
        for (int i = 0; i < 20 && !done; i++) tick();
        chk("done_reached", int'(done), 1);
        chk("ready_in_done", int'(ready), 0);
        chk("latency_ignored", cyc - acc1, N);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("ready_idle", int'(ready), 1);
        tick();
        chk("ready_not_accepted", int'(ready), 1);
        chk("product_ignored", int'(prod), 63);

        // Start held high: back-to-back operations.
        start = 1'b1;
        a     = 8'd5;
        b     = 8'd6;
        tick();
        acc1  = cyc;
        exp_q.push_back(16'd30);
        a     = 8'd12;
        b     = 8'd12;
        exp_q.push_back(16'd144);
        for (int i = 0; i < 30 && !ready; i++) tick();
        tick();
        acc2  = cyc;
        start = 1'b0;
        chk("accept_period", acc2 - acc1, N + 2);
        d1 = last_done_cyc;
        chk("held_latency", d1 - acc1, N);
        wait_done(d2);
        chk("done_period", d2 - d1, N + 2);

        // Reset aborts an operation in flight.
        start = 1'b1;
        a     = 8'd100;
        b     = 8'd100;
        tick();
        start = 1'b0;
        exp_q.push_back(16'd10000);
        dcnt0 = done_cnt;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        void'(exp_q.pop_back());
        chk("abort_ready", int'(ready), 1);
        chk("abort_product", int'(prod), 0);
        chk("abort_done", int'(done), 0);
        for (int i = 0; i < 12; i++) tick();
        chk("abort_no_done", done_cnt - dcnt0, 0);
        op(8'd3, 8'd4, 16'd12);

        tick();
        tick();
        chk("queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", m_tests + s_tests, m_fail + s_fail);
        $finish;
    end

endmodule
